// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and MEM-stage load/store.
// Serialises both onto one SRAM-style bus, raises pipeline stalls and turns a hung bus into an error.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    input  logic        flush,
    output logic        bus_cyc,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stallreq_if,
    output logic        stallreq_mem,
    output logic        bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, IF_BUS, MEM_BUS, RESP} state_t;

    state_t            state, state_d;
    logic              drop, drop_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              bus_cyc_d, bus_we_d, if_ack_d, mem_ack_d, bus_err_d;
    logic [3:0]        bus_sel_d;
    logic [31:0]       bus_addr_d, bus_wdata_d, if_rdata_d, mem_rdata_d;
    logic              drop_now;
    logic              done;

    // A flush in the current bus cycle must suppress an ack issued on this same edge.
    assign drop_now = drop | flush;
    assign done     = bus_ack | (cnt == CNT_LAST);

    assign stallreq_if  = if_req & ~if_ack;
    assign stallreq_mem = mem_req & ~mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            drop      <= 1'b0;
            cnt       <= '0;
            bus_cyc   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= 4'h0;
            bus_addr  <= 32'h0;
            bus_wdata <= 32'h0;
            if_ack    <= 1'b0;
            if_rdata  <= 32'h0;
            mem_ack   <= 1'b0;
            mem_rdata <= 32'h0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_d;
            drop      <= drop_d;
            cnt       <= cnt_d;
            bus_cyc   <= bus_cyc_d;
            bus_we    <= bus_we_d;
            bus_sel   <= bus_sel_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            if_ack    <= if_ack_d;
            if_rdata  <= if_rdata_d;
            mem_ack   <= mem_ack_d;
            mem_rdata <= mem_rdata_d;
            bus_err   <= bus_err_d;
        end
    end

    // Next-state and registered-output logic; bus fields hold between transactions.
    always_comb begin
        state_d     = state;
        drop_d      = drop;
        cnt_d       = cnt;
        bus_cyc_d   = bus_cyc;
        bus_we_d    = bus_we;
        bus_sel_d   = bus_sel;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        if_ack_d    = 1'b0;
        if_rdata_d  = if_rdata;
        mem_ack_d   = 1'b0;
        mem_rdata_d = mem_rdata;
        bus_err_d   = 1'b0;

        case (state)
            IDLE: begin
                drop_d = 1'b0;
                if (!flush && mem_req) begin
                    state_d     = MEM_BUS;
                    cnt_d       = '0;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                end else if (!flush && if_req) begin
                    state_d     = IF_BUS;
                    cnt_d       = '0;
                    bus_cyc_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'hF;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = 32'h0;
                end
            end
            IF_BUS, MEM_BUS: begin
                drop_d = drop_now;
                if (done) begin
                    state_d   = RESP;
                    bus_cyc_d = 1'b0;
                    bus_err_d = ~bus_ack;
                    if (!drop_now) begin
                        if (state == IF_BUS) begin
                            if_ack_d   = 1'b1;
                            if_rdata_d = bus_ack ? bus_rdata : 32'h0;
                        end else begin
                            mem_ack_d   = 1'b1;
                            mem_rdata_d = (bus_ack && !bus_we) ? bus_rdata : 32'h0;
                        end
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (TIMEOUT = 4).
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        ir;
        logic [31:0] ia;
        logic        mr;
        logic        mw;
        logic [3:0]  ms;
        logic [31:0] ma;
        logic [31:0] md;
        logic        fl;
        logic        ba;
        logic [31:0] brd;
    } in_t;

    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        iack;
        logic [31:0] ird;
        logic        mack;
        logic [31:0] mrd;
        logic        err;
        logic        sif;
        logic        smem;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk, rst_n;
    logic        if_req, mem_req, mem_we, flush, bus_ack;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_sel;
    logic        if_ack, mem_ack, bus_cyc, bus_we, stallreq_if, stallreq_mem, bus_err;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;

    int   nvec;
    int   nfail;
    vec_t vecs[$];

    mem_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .flush(flush),
        .bus_cyc(bus_cyc), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic mr, logic mw, logic [3:0] ms,
                                  logic [31:0] ma, logic [31:0] md, logic fl, logic ba,
                                  logic [31:0] brd);
        in_t r;
        r.ir = ir; r.ia = ia; r.mr = mr; r.mw = mw; r.ms = ms;
        r.ma = ma; r.md = md; r.fl = fl; r.ba = ba; r.brd = brd;
        return r;
    endfunction

    function automatic out_t mk_out(logic cyc, logic we, logic [3:0] sel, logic [31:0] addr,
                                    logic [31:0] wd, logic iack, logic [31:0] ird, logic mack,
                                    logic [31:0] mrd, logic err, logic sif, logic smem);
        out_t r;
        r.cyc = cyc; r.we = we; r.sel = sel; r.addr = addr; r.wd = wd; r.iack = iack;
        r.ird = ird; r.mack = mack; r.mrd = mrd; r.err = err; r.sif = sif; r.smem = smem;
        return r;
    endfunction

    function automatic void add(in_t i, out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endfunction

    task automatic apply(in_t i);
        if_req = i.ir; if_addr = i.ia; mem_req = i.mr; mem_we = i.mw; mem_sel = i.ms;
        mem_addr = i.ma; mem_wdata = i.md; flush = i.fl; bus_ack = i.ba; bus_rdata = i.brd;
    endtask

    task automatic check(string name, out_t e);
        out_t g;
        g = mk_out(bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata, if_ack, if_rdata,
                   mem_ack, mem_rdata, bus_err, stallreq_if, stallreq_mem);
        nvec++;
        if (g !== e) begin
            nfail++;
            $display("FAIL %s got cyc=%b we=%b sel=%h addr=%h wd=%h iack=%b ird=%h mack=%b mrd=%h err=%b sif=%b smem=%b | want cyc=%b we=%b sel=%h addr=%h wd=%h iack=%b ird=%h mack=%b mrd=%h err=%b sif=%b smem=%b",
                     name, g.cyc, g.we, g.sel, g.addr, g.wd, g.iack, g.ird, g.mack, g.mrd, g.err, g.sif, g.smem,
                     e.cyc, e.we, e.sel, e.addr, e.wd, e.iack, e.ird, e.mack, e.mrd, e.err, e.sif, e.smem);
        end
    endtask

    initial begin
        in_t  z;
        in_t  fe1, st1, ld2, ld4, f8, fc;
        out_t hold;

        nvec  = 0;
        nfail = 0;
        z   = mk_in(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        fe1 = mk_in(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        st1 = mk_in(0, 32'h0, 1, 1, 4'h3, 32'h300, 32'h1234, 0, 0, 32'h0);
        ld2 = mk_in(1, 32'h104, 1, 0, 4'hF, 32'h200, 32'h0, 0, 0, 32'h0);
        ld4 = mk_in(0, 32'h0, 1, 0, 4'hF, 32'h400, 32'h0, 0, 0, 32'h0);
        f8  = mk_in(1, 32'h108, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        fc  = mk_in(1, 32'h10C, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0);

        // single fetch, bus_ack on the third bus cycle
        add(fe1, mk_out(0, 0, 4'h0, 32'h0,   32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        add(fe1, mk_out(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        add(fe1, mk_out(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        add(mk_in(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hDEADBEEF),
            mk_out(1, 0, 4'hF, 32'h100, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        add(fe1, mk_out(0, 0, 4'hF, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0, 0));
        // store with partial byte enables
        add(st1, mk_out(0, 0, 4'hF, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0, 1));
        add(st1, mk_out(1, 1, 4'h3, 32'h300, 32'h1234, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0, 1));
        add(mk_in(0, 32'h0, 1, 1, 4'h3, 32'h300, 32'h1234, 0, 1, 32'hFFFFFFFF),
            mk_out(1, 1, 4'h3, 32'h300, 32'h1234, 0, 32'hDEADBEEF, 0, 32'h0, 0, 0, 1));
        add(st1, mk_out(0, 1, 4'h3, 32'h300, 32'h1234, 0, 32'hDEADBEEF, 1, 32'h0, 0, 0, 0));
        // simultaneous load + fetch: MEM first, RESP gap, then fetch
        add(ld2, mk_out(0, 1, 4'h3, 32'h300, 32'h1234, 0, 32'hDEADBEEF, 0, 32'h0, 0, 1, 1));
        add(mk_in(1, 32'h104, 1, 0, 4'hF, 32'h200, 32'h0, 0, 1, 32'hCAFEF00D),
            mk_out(1, 0, 4'hF, 32'h200, 32'h0, 0, 32'hDEADBEEF, 0, 32'h0, 0, 1, 1));
        add(ld2, mk_out(0, 0, 4'hF, 32'h200, 32'h0, 0, 32'hDEADBEEF, 1, 32'hCAFEF00D, 0, 1, 0));
        add(mk_in(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0),
            mk_out(0, 0, 4'hF, 32'h200, 32'h0, 0, 32'hDEADBEEF, 0, 32'hCAFEF00D, 0, 1, 0));
        add(mk_in(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h11112222),
            mk_out(1, 0, 4'hF, 32'h104, 32'h0, 0, 32'hDEADBEEF, 0, 32'hCAFEF00D, 0, 1, 0));
        add(mk_in(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0),
            mk_out(0, 0, 4'hF, 32'h104, 32'h0, 1, 32'h11112222, 0, 32'hCAFEF00D, 0, 0, 0));
        // flush mid-load: bus completes, no ack, mem_rdata unchanged
        add(ld4, mk_out(0, 0, 4'hF, 32'h104, 32'h0, 0, 32'h11112222, 0, 32'hCAFEF00D, 0, 0, 1));
        add(mk_in(0, 32'h0, 1, 0, 4'hF, 32'h400, 32'h0, 1, 0, 32'h0),
            mk_out(1, 0, 4'hF, 32'h400, 32'h0, 0, 32'h11112222, 0, 32'hCAFEF00D, 0, 0, 1));
        add(mk_in(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'hABCD0000),
            mk_out(1, 0, 4'hF, 32'h400, 32'h0, 0, 32'h11112222, 0, 32'hCAFEF00D, 0, 0, 0));
        hold = mk_out(0, 0, 4'hF, 32'h400, 32'h0, 0, 32'h11112222, 0, 32'hCAFEF00D, 0, 0, 0);
        add(z, hold);
        add(z, hold);
        // request during flush in IDLE is ignored, granted once flush drops
        hold.sif = 1'b1;
        add(mk_in(1, 32'h108, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h0), hold);
        add(f8, hold);
        // timeout: four bus cycles, error pulse, ack with zero data
        for (int k = 0; k < 4; k++)
            add(f8, mk_out(1, 0, 4'hF, 32'h108, 32'h0, 0, 32'h11112222, 0, 32'hCAFEF00D, 0, 1, 0));
        add(f8, mk_out(0, 0, 4'hF, 32'h108, 32'h0, 1, 32'h0, 0, 32'hCAFEF00D, 1, 0, 0));
        add(z,  mk_out(0, 0, 4'hF, 32'h108, 32'h0, 0, 32'h0, 0, 32'hCAFEF00D, 0, 0, 0));
        // bus_ack on the timeout cycle counts as success
        add(fc, mk_out(0, 0, 4'hF, 32'h108, 32'h0, 0, 32'h0, 0, 32'hCAFEF00D, 0, 1, 0));
        for (int k = 0; k < 3; k++)
            add(fc, mk_out(1, 0, 4'hF, 32'h10C, 32'h0, 0, 32'h0, 0, 32'hCAFEF00D, 0, 1, 0));
        add(mk_in(1, 32'h10C, 0, 0, 4'h0, 32'h0, 32'h0, 0, 1, 32'h55AA55AA),
            mk_out(1, 0, 4'hF, 32'h10C, 32'h0, 0, 32'h0, 0, 32'hCAFEF00D, 0, 1, 0));
        add(fc, mk_out(0, 0, 4'hF, 32'h10C, 32'h0, 1, 32'h55AA55AA, 0, 32'hCAFEF00D, 0, 0, 0));
        add(z,  mk_out(0, 0, 4'hF, 32'h10C, 32'h0, 0, 32'h55AA55AA, 0, 32'hCAFEF00D, 0, 0, 0));

        // reset state
        apply(z);
        rst_n = 1'b0;
        #1;
        check("reset", mk_out(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            apply(vecs[n].i);
            #1;
            check($sformatf("vec%0d", n), vecs[n].o);
        end

        // asynchronous reset while bus_cyc is high
        @(negedge clk);
        apply(mk_in(1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0));
        @(posedge clk);
        #1;
        check("grant_before_reset",
              mk_out(1, 0, 4'hF, 32'h200, 32'h0, 0, 32'h55AA55AA, 0, 32'hCAFEF00D, 0, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk_out(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0));
        @(negedge clk);
        apply(z);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_release", mk_out(0, 0, 4'h0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0));
        apply(mk_in(0, 32'h0, 1, 0, 4'hF, 32'h500, 32'h0, 0, 0, 32'h0));
        @(posedge clk);
        #1;
        check("post_reset_grant", mk_out(1, 0, 4'hF, 32'h500, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 1));
        @(negedge clk);
        apply(mk_in(0, 32'h0, 1, 0, 4'hF, 32'h500, 32'h0, 0, 1, 32'h77778888));
        @(posedge clk);
        #1;
        check("post_reset_ack", mk_out(0, 0, 4'hF, 32'h500, 32'h0, 0, 32'h0, 1, 32'h77778888, 0, 0, 0));
        @(negedge clk);
        apply(z);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
